// File: rtl/magnetron_ctrl_if.sv
// Front-panel, interlock and drive signals of the magnetron controller.
// The bench drives through master; the controller receives through slave.
interface magnetron_ctrl_if #(
   parameter int TIME_W     = 12,
   parameter int PWR_LEVELS = 10
);
   localparam int PWR_W = $clog2(PWR_LEVELS + 1);

   logic              door_closed;
   logic              startn;
   logic              stopn;
   logic              clearn;
   logic              time_wr;
   logic [TIME_W-1:0] time_in;
   logic [PWR_W-1:0]  power;
   logic              mag_on;
   logic              mag_onn;
   logic [TIME_W-1:0] remaining;
   logic [1:0]        state;
   logic              timer_done;

   modport master (
      output door_closed, startn, stopn, clearn, time_wr, time_in, power,
      input  mag_on, mag_onn, remaining, state, timer_done
   );

   modport slave (
      input  door_closed, startn, stopn, clearn, time_wr, time_in, power,
      output mag_on, mag_onn, remaining, state, timer_done
   );
endinterface

// File: rtl/magnetron_ctrl.sv
// Microwave magnetron sequencer: seconds countdown, duty-slot power control
// and door interlock, all outputs registered.
//
// state | meaning
// IDLE  | no cooking; time may be loaded
// COOK  | counting down, magnetron driven per duty slot
// PAUSE | door open / stop; counters frozen, time may be reloaded
// DONE  | countdown reached zero; wait for clear or door open
module magnetron_ctrl #(
   parameter int TIME_W        = 12,
   parameter int TICKS_PER_SEC = 1000,
   parameter int PWR_LEVELS    = 10
) (
   input logic             clk,
   input logic             rst_n,
   magnetron_ctrl_if.slave bus
);
   localparam int PWR_W  = $clog2(PWR_LEVELS + 1);
   localparam int TICK_W = $clog2(TICKS_PER_SEC);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
   localparam logic [PWR_W-1:0]  DUTY_LAST = PWR_W'(PWR_LEVELS - 1);
   localparam logic [PWR_W-1:0]  PWR_MAX   = PWR_W'(PWR_LEVELS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COOK  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [TIME_W-1:0]   remaining_q, remaining_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [PWR_W-1:0]    duty_q, duty_d;
   logic                mag_on_q, mag_on_d;
   logic                timer_done_q, timer_done_d;
   logic [PWR_W-1:0]    pwr_sat;
   logic                tick_wrap;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         remaining_q  <= '0;
         tick_q       <= '0;
         duty_q       <= '0;
         mag_on_q     <= 1'b0;
         timer_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         tick_q       <= tick_d;
         duty_q       <= duty_d;
         mag_on_q     <= mag_on_d;
         timer_done_q <= timer_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      tick_d       = tick_q;
      duty_d       = duty_q;
      timer_done_d = 1'b0;
      pwr_sat      = (bus.power > PWR_MAX) ? PWR_MAX : bus.power;
      tick_wrap    = (tick_q == TICK_LAST);

      case (state_q)
         ST_IDLE, ST_PAUSE: begin
            if (!bus.door_closed) begin
               state_d = state_q;
            end else if (!bus.clearn) begin
               state_d     = ST_IDLE;
               remaining_d = '0;
               tick_d      = '0;
               duty_d      = '0;
            end else if (!bus.stopn) begin
               state_d = state_q;
            end else if (!bus.startn) begin
               if (remaining_q != '0) state_d = ST_COOK;
            end else if (bus.time_wr) begin
               remaining_d = bus.time_in;
               tick_d      = '0;
               duty_d      = '0;
            end
         end

         ST_COOK: begin
            // Every cycle spent in COOK is counted, including the one that
            // ends in a pause, so accumulated on-time equals cook time.
            tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
            if (tick_wrap) begin
               duty_d = (duty_q == DUTY_LAST) ? '0 : duty_q + PWR_W'(1);
               if (remaining_q != '0) remaining_d = remaining_q - TIME_W'(1);
            end
            if (tick_wrap && remaining_q == TIME_W'(1)) begin
               state_d      = ST_DONE;
               timer_done_d = 1'b1;
            end else if (!bus.door_closed || !bus.clearn || !bus.stopn) begin
               state_d = ST_PAUSE;
            end
         end

         ST_DONE: begin
            if (!bus.door_closed || !bus.clearn) begin
               state_d     = ST_IDLE;
               remaining_d = '0;
               tick_d      = '0;
               duty_d      = '0;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      mag_on_d = (state_d == ST_COOK) && bus.door_closed && (duty_d < pwr_sat);
   end

   assign bus.mag_on     = mag_on_q;
   assign bus.mag_onn    = ~mag_on_q;
   assign bus.remaining  = remaining_q;
   assign bus.state      = state_q;
   assign bus.timer_done = timer_done_q;
endmodule

// File: tb/tb_magnetron_ctrl.sv
// Directed bench for magnetron_ctrl: countdown, duty, interlock, reset, width sweep.
module tb_magnetron_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_bad = 0;
   int   on_acc, done_acc, onn_bad;

   always #5 clk = ~clk;

   magnetron_ctrl_if #(.TIME_W(12), .PWR_LEVELS(10)) bus ();
   magnetron_ctrl_if #(.TIME_W(4),  .PWR_LEVELS(10)) bus4 ();

   magnetron_ctrl #(.TIME_W(12), .TICKS_PER_SEC(4), .PWR_LEVELS(10)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   magnetron_ctrl #(.TIME_W(4), .TICKS_PER_SEC(2), .PWR_LEVELS(10)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // advance n clock edges, sampling 1 ns after each rising edge
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         on_acc   += 32'(bus.mag_on);
         done_acc += 32'(bus.timer_done);
         if (bus.mag_onn == bus.mag_on) onn_bad++;
      end
   endtask

   task automatic clr_acc();
      on_acc = 0;
      done_acc = 0;
   endtask

   task automatic load(input int t);
      bus.time_wr = 1'b1;
      bus.time_in = 12'(t);
      tick(1);
      bus.time_wr = 1'b0;
   endtask

   task automatic pulse_start();
      bus.startn = 1'b0;
      tick(1);
      bus.startn = 1'b1;
   endtask

   task automatic pulse_clear();
      bus.clearn = 1'b0;
      tick(1);
      bus.clearn = 1'b1;
   endtask

   initial begin
      onn_bad = 0;
      clr_acc();
      rst_n = 1'b0;
      bus.door_closed = 1'b1; bus.startn = 1'b1; bus.stopn = 1'b1;
      bus.clearn = 1'b1; bus.time_wr = 1'b0; bus.time_in = '0; bus.power = 4'd10;
      bus4.door_closed = 1'b1; bus4.startn = 1'b1; bus4.stopn = 1'b1;
      bus4.clearn = 1'b1; bus4.time_wr = 1'b0; bus4.time_in = '0; bus4.power = 4'd15;

      // reset state
      tick(2);
      chk("rst_state", 32'(bus.state), 0);
      chk("rst_rem", 32'(bus.remaining), 0);
      chk("rst_mag", 32'(bus.mag_on), 0);
      chk("rst_magn", 32'(bus.mag_onn), 1);
      chk("rst_done", 32'(bus.timer_done), 0);
      rst_n = 1'b1;
      tick(1);

      // 3 s at full power
      load(3);
      chk("load_rem", 32'(bus.remaining), 3);
      clr_acc();
      pulse_start();
      chk("t1_cook", 32'(bus.state), 1);
      chk("t1_mag", 32'(bus.mag_on), 1);
      tick(4);
      chk("t1_rem2", 32'(bus.remaining), 2);
      tick(4);
      chk("t1_rem1", 32'(bus.remaining), 1);
      tick(3);
      chk("t1_still_cook", 32'(bus.state), 1);
      tick(1);
      chk("t1_done_state", 32'(bus.state), 3);
      chk("t1_done_pulse", 32'(bus.timer_done), 1);
      chk("t1_rem0", 32'(bus.remaining), 0);
      chk("t1_mag_off", 32'(bus.mag_on), 0);
      chk("t1_on_cycles", on_acc, 12);
      tick(2);
      chk("t1_pulse_once", done_acc, 1);
      pulse_start();
      chk("t1_start_in_done", 32'(bus.state), 3);
      pulse_clear();
      chk("t1_clear_idle", 32'(bus.state), 0);

      // door opened mid-cook, then resumed
      load(3);
      clr_acc();
      pulse_start();
      tick(5);
      bus.door_closed = 1'b0;
      tick(1);
      chk("t2_pause", 32'(bus.state), 2);
      chk("t2_interlock", 32'(bus.mag_on), 0);
      chk("t2_rem_held", 32'(bus.remaining), 2);
      tick(3);
      chk("t2_rem_held2", 32'(bus.remaining), 2);
      bus.door_closed = 1'b1;
      tick(1);
      chk("t2_no_autostart", 32'(bus.state), 2);
      pulse_start();
      chk("t2_resume", 32'(bus.state), 1);
      tick(1);
      chk("t2_r1_rem", 32'(bus.remaining), 2);
      tick(1);
      chk("t2_r2_rem", 32'(bus.remaining), 1);
      tick(3);
      chk("t2_r5_cook", 32'(bus.state), 1);
      tick(1);
      chk("t2_done", 32'(bus.state), 3);
      chk("t2_on_cycles", on_acc, 12);
      chk("t2_pulses", done_acc, 1);
      pulse_clear();

      // power 3 of 10 over 10 s
      bus.power = 4'd3;
      load(10);
      clr_acc();
      pulse_start();
      tick(11);
      chk("t3_on_first3s", on_acc, 12);
      chk("t3_mag_s2", 32'(bus.mag_on), 1);
      tick(1);
      chk("t3_mag_s3", 32'(bus.mag_on), 0);
      chk("t3_rem7", 32'(bus.remaining), 7);
      tick(27);
      chk("t3_rem1_c39", 32'(bus.remaining), 1);
      tick(1);
      chk("t3_rem0_c40", 32'(bus.remaining), 0);
      chk("t3_done", 32'(bus.state), 3);
      chk("t3_on_total", on_acc, 12);
      chk("t3_pulses", done_acc, 1);
      pulse_clear();

      // ignored requests
      pulse_start();
      chk("t4_start_rem0", 32'(bus.state), 0);
      load(5);
      chk("t4_load5", 32'(bus.remaining), 5);
      bus.startn = 1'b0;
      bus.stopn = 1'b0;
      tick(1);
      bus.startn = 1'b1;
      bus.stopn = 1'b1;
      chk("t4_start_stop", 32'(bus.state), 0);
      bus.power = 4'd10;
      pulse_start();
      chk("t4_cook", 32'(bus.state), 1);
      bus.time_wr = 1'b1;
      bus.time_in = 12'd9;
      tick(1);
      bus.time_wr = 1'b0;
      chk("t4_wr_in_cook", 32'(bus.remaining), 5);
      bus.power = 4'd0;
      tick(1);
      chk("t4_pwr0_mag", 32'(bus.mag_on), 0);
      chk("t4_pwr0_state", 32'(bus.state), 1);
      tick(2);
      chk("t4_pwr0_counts", 32'(bus.remaining), 4);

      // reset mid-cook
      clr_acc();
      rst_n = 1'b0;
      tick(1);
      chk("t5_state", 32'(bus.state), 0);
      chk("t5_rem", 32'(bus.remaining), 0);
      chk("t5_mag", 32'(bus.mag_on), 0);
      chk("t5_magn", 32'(bus.mag_onn), 1);
      chk("t5_no_done", done_acc, 0);
      rst_n = 1'b1;
      tick(1);

      // clear in pause
      bus.power = 4'd10;
      load(2);
      pulse_start();
      bus.stopn = 1'b0;
      tick(1);
      bus.stopn = 1'b1;
      chk("t6_pause", 32'(bus.state), 2);
      chk("t6_pause_rem", 32'(bus.remaining), 2);
      pulse_clear();
      chk("t6_clear_state", 32'(bus.state), 0);
      chk("t6_clear_rem", 32'(bus.remaining), 0);

      // 4-bit timer at its maximum, 2 ticks per second
      bus4.time_wr = 1'b1;
      bus4.time_in = 4'd15;
      tick(1);
      bus4.time_wr = 1'b0;
      chk("t7_load15", 32'(bus4.remaining), 15);
      bus4.startn = 1'b0;
      tick(1);
      bus4.startn = 1'b1;
      chk("t7_cook", 32'(bus4.state), 1);
      chk("t7_mag_sat", 32'(bus4.mag_on), 1);
      tick(29);
      chk("t7_rem1", 32'(bus4.remaining), 1);
      chk("t7_mag_late", 32'(bus4.mag_on), 1);
      tick(1);
      chk("t7_rem0", 32'(bus4.remaining), 0);
      chk("t7_done", 32'(bus4.state), 3);
      chk("t7_pulse", 32'(bus4.timer_done), 1);
      tick(5);
      chk("t7_no_wrap", 32'(bus4.remaining), 0);
      chk("t7_stays_done", 32'(bus4.state), 3);

      chk("mag_onn_complement", onn_bad, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
